hs_pulse_tx: RTL and testbench

Single-clock transmit end of a 4-phase req/ack handshake. A one-cycle request pulse plus data is converted into a held req level. req stays high until the receiving side acknowledges it, then returns to zero. The receiving side turns req back into a pulse with its own edge detector.
The block sits in the source clock domain, ahead of the bit/bus synchronizer toward the destination domain. The ack input arrives already synchronized into CLK by an external bit synchronizer.

---
 rtl/hs_pulse_tx_pkg.sv | 14 +
 rtl/hs_pulse_tx.sv | 87 ++++++++
 tb/tb_hs_pulse_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hs_pulse_tx_pkg.sv
// Shared state encoding and default parameters for the 4-phase handshake transmitter.
package hs_pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_HI = 2'b01,
    ACK_LO = 2'b10
  } hs_state_t;

  localparam int HS_DATA_WIDTH = 8;
  localparam int HS_TIMEOUT    = 255;
  localparam int HS_CNT_WIDTH  = 16;

endpackage

// File: rtl/hs_pulse_tx.sv
// Transmit side of a 4-phase req/ack handshake: turns a one-cycle request pulse
// into a held req level with payload, released by ack or by a timeout.
module hs_pulse_tx
  import hs_pulse_tx_pkg::*;
#(
  parameter int DATA_WIDTH = HS_DATA_WIDTH,
  parameter int TIMEOUT    = HS_TIMEOUT,
  parameter int CNT_WIDTH  = HS_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  pulse_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ack,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  drop_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  hs_state_t             state, next_state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  timed_out;   // current handshake was released by timeout
  logic                  accept, expire;
  logic                  req_d, busy_d, done_d, timeout_d, drop_d;

  assign accept = (state == IDLE) && pulse_in;
  assign expire = (state == REQ_HI) && !ack && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pulse_in)       next_state = REQ_HI;
      REQ_HI:  if (ack || expire)  next_state = ACK_LO;
      ACK_LO:  if (!ack)           next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_d     = (next_state == REQ_HI);
    busy_d    = (next_state != IDLE);
    done_d    = (state == ACK_LO) && !ack && !timed_out;
    timeout_d = expire;
    drop_d    = pulse_in && (state != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      drop_err    <= 1'b0;
      data_out    <= '0;
      cnt         <= '0;
      timed_out   <= 1'b0;
    end else begin
      req         <= req_d;
      busy        <= busy_d;
      done        <= done_d;
      timeout_err <= timeout_d;
      drop_err    <= drop_d;
      if (accept) begin
        data_out  <= data_in;
        cnt       <= '0;
        timed_out <= 1'b0;
      end else begin
        if (state == REQ_HI && cnt != '1) cnt <= cnt + 1'b1;  // saturating
        if (expire) timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_pulse_tx.sv
// Directed bench for hs_pulse_tx: default-TIMEOUT instance for the handshake,
// drop and reset cases, TIMEOUT=4 instance for timeout and ack/timeout tie.
module tb_hs_pulse_tx;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       pulse_in = 1'b0, ack = 1'b0;
  logic [7:0] data_in = '0;
  logic       req, busy, done, timeout_err, drop_err;
  logic [7:0] data_out;

  logic       pulse_in_t = 1'b0, ack_t = 1'b0;
  logic [7:0] data_in_t = '0;
  logic       req_t, busy_t, done_t, timeout_err_t, drop_err_t;
  logic [7:0] data_out_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  always #5 CLK = ~CLK;

  hs_pulse_tx #(.DATA_WIDTH(8), .TIMEOUT(255), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST_n(RST_n), .pulse_in(pulse_in), .data_in(data_in), .ack(ack),
    .req(req), .data_out(data_out), .busy(busy), .done(done),
    .timeout_err(timeout_err), .drop_err(drop_err)
  );

  hs_pulse_tx #(.DATA_WIDTH(8), .TIMEOUT(4), .CNT_WIDTH(16)) dut_t (
    .CLK(CLK), .RST_n(RST_n), .pulse_in(pulse_in_t), .data_in(data_in_t), .ack(ack_t),
    .req(req_t), .data_out(data_out_t), .busy(busy_t), .done(done_t),
    .timeout_err(timeout_err_t), .drop_err(drop_err_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      pulse_in = i[0]; ack = ~i[0]; data_in = 8'hFF;
      tick();
    end
    chk("rst_req", req, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_drop", drop_err, 1'b0);
    pulse_in = 1'b0; ack = 1'b0;
    RST_n = 1'b1;
    tick();

    // Accept A5
    pulse_in = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    pulse_in = 1'b0;
    chk("acc_req", req, 1'b1);
    chk("acc_busy", busy, 1'b1);
    chk("acc_data", data_out, 8'hA5);

    // Drop while req high
    pulse_in = 1'b1; data_in = 8'h3C;
    tick();
    pulse_in = 1'b0;
    chk("drop_err", drop_err, 1'b1);
    chk("drop_req", req, 1'b1);
    chk("drop_data", data_out, 8'hA5);
    tick();
    chk("drop_pulse1", drop_err, 1'b0);

    // ack rises -> req falls next edge
    ack = 1'b1;
    tick();
    chk("ack_req", req, 1'b0);
    chk("ack_busy", busy, 1'b1);
    tick();
    chk("acklo_wait_done", done, 1'b0);
    chk("acklo_wait_req", req, 1'b0);
    ack = 1'b0;
    tick();
    chk("hs_done", done, 1'b1);
    chk("hs_busy", busy, 1'b0);
    exp_d = exp_q.pop_front();
    chk("sb_data", data_out, exp_d);

    // Earliest re-accept on the edge after busy reads 0
    pulse_in = 1'b1; data_in = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    pulse_in = 1'b0;
    chk("done_pulse1", done, 1'b0);
    chk("reacc_req", req, 1'b1);
    chk("reacc_data", data_out, 8'h5A);
    chk("reacc_drop", drop_err, 1'b0);

    // Async reset mid-transfer with ack high
    ack = 1'b1;
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_req", req, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", data_out, 8'h00);
    exp_q.delete();
    tick();
    ack = 1'b0;
    RST_n = 1'b1;
    tick();
    pulse_in = 1'b1; data_in = 8'h77; exp_q.push_back(8'h77);
    tick();
    pulse_in = 1'b0;
    chk("post_rst_req", req, 1'b1);
    chk("post_rst_data", data_out, 8'h77);
    ack = 1'b1;
    tick();
    chk("post_rst_ack", req, 1'b0);
    ack = 1'b0;
    tick();
    chk("post_rst_done", done, 1'b1);
    exp_d = exp_q.pop_front();
    chk("sb_data2", data_out, exp_d);

    // Timeout with TIMEOUT=4: req high exactly 4 cycles
    pulse_in_t = 1'b1; data_in_t = 8'hC3;
    tick();
    pulse_in_t = 1'b0;
    chk("to_req0", req_t, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to_req%0d", i), req_t, 1'b1);
      chk($sformatf("to_err%0d", i), timeout_err_t, 1'b0);
    end
    tick();
    chk("to_req_fall", req_t, 1'b0);
    chk("to_err", timeout_err_t, 1'b1);
    chk("to_busy", busy_t, 1'b1);
    chk("to_nodone", done_t, 1'b0);
    tick();
    chk("to_idle_busy", busy_t, 1'b0);
    chk("to_idle_done", done_t, 1'b0);
    chk("to_err_pulse1", timeout_err_t, 1'b0);
    chk("to_data_hold", data_out_t, 8'hC3);

    // ack arrives on the same edge the timeout would fire
    pulse_in_t = 1'b1; data_in_t = 8'h96;
    tick();
    pulse_in_t = 1'b0;
    tick(); tick(); tick();
    ack_t = 1'b1;
    tick();
    chk("tie_req", req_t, 1'b0);
    chk("tie_noerr", timeout_err_t, 1'b0);
    ack_t = 1'b0;
    tick();
    chk("tie_done", done_t, 1'b1);
    chk("tie_busy", busy_t, 1'b0);
    chk("tie_data", data_out_t, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
